biriscv_fetch_buffer: RTL and testbench
=======================================

BIRISCV_FETCH_BUFFER -- requirements
Module: biriscv_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, packet entries held (power of 2, >=2).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port fetch_valid_i  input  1  fetch packet valid.
REQ-005 SHALL have port fetch_instr_i  input  64  two instructions; [31:0] slot0 at PC+0, [63:32] slot1 at PC+4.
REQ-006 SHALL have port fetch_pc_i  input  32  packet PC, 8-byte aligned; bits [2:0] ignored.
REQ-007 SHALL have port fetch_pred_branch_i  input  2  per-slot predicted-taken flags.
REQ-008 SHALL have port fetch_fault_i  input  2  {page fault, fetch fault} for the packet.
REQ-009 SHALL have port fetch_accept_o  output  1  buffer can take a packet this cycle.
REQ-010 SHALL have port flush_i  input  1  discard all buffered packets.
REQ-011 SHALL have port issue0_valid_o  output  1  slot-0 issue instruction valid.
REQ-012 SHALL have port issue0_instr_o  output  32  slot-0 instruction.
REQ-013 SHALL have port issue0_pc_o  output  32  slot-0 instruction PC.
REQ-014 SHALL have port issue0_fault_o  output  2  slot-0 {page, fetch} fault.
REQ-015 SHALL have port issue0_pred_o  output  1  slot-0 predicted taken.
REQ-016 SHALL have port issue0_accept_i  input  1  consumer takes issue0.
REQ-017 SHALL have ports issue1_valid_o/instr_o/pc_o/fault_o/pred_o  output  1/32/32/2/1  slot-1 equivalents.
REQ-018 SHALL have port issue1_accept_i  input  1  consumer takes issue1.

Function
REQ-019 SHALL store packets in a DEPTH-entry circular FIFO: instr, pc[31:3], pred[1:0], fault[1:0], plus a head-only lo_done bit.
REQ-020 SHALL push when fetch_valid_i && fetch_accept_o && !flush_i; write pointer wraps modulo DEPTH.
REQ-021 SHALL drive fetch_accept_o = (count < DEPTH), from registered count only, not from same-cycle pops.
REQ-022 SHALL present head as: lo_done=0 -> issue0 = low word, PC {pc,3'b000}; lo_done=1 -> issue0 = high word, PC {pc,3'b100}.
REQ-023 SHALL assert issue1_valid_o only when head non-empty, lo_done=0, pred[0]=0, fault=0; issue1 = high word, PC {pc,3'b100}.
REQ-024 SHALL, for a packet with pred[0]=1 or any fault bit set, never issue its high word; packet retires after its low word.
REQ-025 SHALL drive issue0_fault_o = head fault; issue1_fault_o = 0; issueN_pred_o = pred bit of issued word.
REQ-026 SHALL ignore issue1_accept_i unless issue0_accept_i and issue1_valid_o are both high that cycle.
REQ-027 SHALL pop head (read pointer +1 mod DEPTH, lo_done<=0) when accepts consume its last issuable word; else set lo_done<=1 on issue0-only accept of low word.
REQ-028 SHALL count: +1 on push, -1 on pop, unchanged on both; push and pop same cycle legal when count<DEPTH.
REQ-029 SHALL assert issue0_valid_o iff count != 0; outputs derived from state only (no fetch_* bypass into same cycle).
REQ-030 SHALL on flush_i clear count, pointers, lo_done next edge; flush dominates push and pop that cycle.
REQ-031 SHALL ignore accepts when corresponding valid low; no underflow, no overflow.

Reset
REQ-032 SHALL on rst_i=1 at clock edge set count=0, pointers=0, lo_done=0; rst_i dominates flush_i and push.
REQ-033 SHALL after reset output fetch_accept_o=1, issue0_valid_o=0, issue1_valid_o=0; data outputs don't-care while invalid.
REQ-034 SHALL treat reset asserted mid-operation identically to flush: all buffered packets lost, no partial issue afterwards.

Verification
REQ-035 SHALL pass: push pc=0x1000, instr=0x00200093_00100093, pred=0, fault=0; accept both -> issue0 pc 0x1000/0x00100093, issue1 pc 0x1004/0x00200093, count returns 0.
REQ-036 SHALL pass: same packet, issue0_accept only -> next cycle issue0 pc 0x1004, issue1_valid_o=0; accept -> pop.
REQ-037 SHALL pass: pred=2'b01 at pc 0x2000 -> issue1_valid_o=0; one issue0 accept pops; following packet pc 0x3000 appears as issue0.
REQ-038 SHALL pass: push 4 packets, no accepts -> fetch_accept_o=0 after 4th; push+dual-accept when count=3 -> count stays 3.
REQ-039 SHALL pass: fault=2'b01 at pc 0x4000 -> issue0_fault_o=2'b01, issue1_valid_o=0; flush_i with 3 queued -> next cycle issue0_valid_o=0, fetch_accept_o=1.
REQ-040 SHALL pass: rst_i asserted with 2 packets queued and lo_done=1 -> next cycle count 0; new packet pc 0x5000 issues from 0x5000, not 0x5004.

Source files
------------

// File: rtl/biriscv_fetch_buffer_if.sv
// Fetch-side and issue-side handshake bundle of the dual-issue fetch buffer.
// The environment holds the master view and the buffer holds the slave view.
interface biriscv_fetch_buffer_if;
  logic        fetch_valid_i;
  logic [63:0] fetch_instr_i;
  logic [31:0] fetch_pc_i;
  logic [1:0]  fetch_pred_branch_i;
  logic [1:0]  fetch_fault_i;
  logic        fetch_accept_o;
  logic        flush_i;

  logic        issue0_valid_o;
  logic [31:0] issue0_instr_o;
  logic [31:0] issue0_pc_o;
  logic [1:0]  issue0_fault_o;
  logic        issue0_pred_o;
  logic        issue0_accept_i;

  logic        issue1_valid_o;
  logic [31:0] issue1_instr_o;
  logic [31:0] issue1_pc_o;
  logic [1:0]  issue1_fault_o;
  logic        issue1_pred_o;
  logic        issue1_accept_i;

  modport master (
    output fetch_valid_i, fetch_instr_i, fetch_pc_i, fetch_pred_branch_i, fetch_fault_i,
    output flush_i, issue0_accept_i, issue1_accept_i,
    input  fetch_accept_o,
    input  issue0_valid_o, issue0_instr_o, issue0_pc_o, issue0_fault_o, issue0_pred_o,
    input  issue1_valid_o, issue1_instr_o, issue1_pc_o, issue1_fault_o, issue1_pred_o
  );

  modport slave (
    input  fetch_valid_i, fetch_instr_i, fetch_pc_i, fetch_pred_branch_i, fetch_fault_i,
    input  flush_i, issue0_accept_i, issue1_accept_i,
    output fetch_accept_o,
    output issue0_valid_o, issue0_instr_o, issue0_pc_o, issue0_fault_o, issue0_pred_o,
    output issue1_valid_o, issue1_instr_o, issue1_pc_o, issue1_fault_o, issue1_pred_o
  );
endinterface

// File: rtl/biriscv_fetch_buffer.sv
// Circular buffer of 64-bit fetch packets feeding a two-wide issue stage.
// The head packet is issued as one or two 32-bit words; lo_done tracks a half-consumed head.
module biriscv_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  biriscv_fetch_buffer_if.slave fb_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [63:0]      instr_q [DEPTH];
  logic [28:0]      pc_q    [DEPTH];
  logic [1:0]       pred_q  [DEPTH];
  logic [1:0]       fault_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lo_done_q, lo_done_d;

  logic [63:0] head_instr;
  logic [28:0] head_pc;
  logic [1:0]  head_pred;
  logic [1:0]  head_fault;
  logic        head_vld;
  logic        hi_blocked;
  logic        push, pop, set_lo, take0, take1;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^fb_if.fetch_pc_i[2:0];

  assign head_instr = instr_q[rd_ptr_q];
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_pred  = pred_q[rd_ptr_q];
  assign head_fault = fault_q[rd_ptr_q];
  assign head_vld   = (count_q != '0);

  // A predicted-taken slot0 or any fault means slot1 is never executed.
  assign hi_blocked = head_pred[0] | (|head_fault);

  assign fb_if.fetch_accept_o = (count_q < CNT_W'(DEPTH));

  assign fb_if.issue0_valid_o = head_vld;
  assign fb_if.issue0_instr_o = lo_done_q ? head_instr[63:32] : head_instr[31:0];
  assign fb_if.issue0_pc_o    = {head_pc, lo_done_q, 2'b00};
  assign fb_if.issue0_fault_o = head_fault;
  assign fb_if.issue0_pred_o  = lo_done_q ? head_pred[1] : head_pred[0];

  assign fb_if.issue1_valid_o = head_vld & ~lo_done_q & ~hi_blocked;
  assign fb_if.issue1_instr_o = head_instr[63:32];
  assign fb_if.issue1_pc_o    = {head_pc, 3'b100};
  assign fb_if.issue1_fault_o = 2'b00;
  assign fb_if.issue1_pred_o  = head_pred[1];

  assign take0  = fb_if.issue0_valid_o & fb_if.issue0_accept_i;
  assign take1  = take0 & fb_if.issue1_valid_o & fb_if.issue1_accept_i;
  assign pop    = take0 & (lo_done_q | hi_blocked | take1);
  assign set_lo = take0 & ~pop;
  assign push   = fb_if.fetch_valid_i & fb_if.fetch_accept_o & ~fb_if.flush_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    lo_done_d = lo_done_q;
    if (fb_if.flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      lo_done_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        lo_done_d = 1'b0;
      end else if (set_lo) begin
        lo_done_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lo_done_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lo_done_q <= lo_done_d;
    end
  end

  // Packet storage carries no reset; validity comes only from count/pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_ptr_q] <= fb_if.fetch_instr_i;
      pc_q[wr_ptr_q]    <= fb_if.fetch_pc_i[31:3];
      pred_q[wr_ptr_q]  <= fb_if.fetch_pred_branch_i;
      fault_q[wr_ptr_q] <= fb_if.fetch_fault_i;
    end
  end
endmodule

// File: tb/tb_biriscv_fetch_buffer.sv
// Directed bench for biriscv_fetch_buffer with hand-computed expectations.
module tb_biriscv_fetch_buffer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  biriscv_fetch_buffer_if fb_if ();

  biriscv_fetch_buffer #(.DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .fb_if (fb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fb_if.fetch_valid_i       = 1'b0;
    fb_if.fetch_instr_i       = 64'h0;
    fb_if.fetch_pc_i          = 32'h0;
    fb_if.fetch_pred_branch_i = 2'b00;
    fb_if.fetch_fault_i       = 2'b00;
    fb_if.flush_i             = 1'b0;
    fb_if.issue0_accept_i     = 1'b0;
    fb_if.issue1_accept_i     = 1'b0;
  endtask

  task automatic set_pkt(input logic [31:0] pc, input logic [63:0] instr,
                         input logic [1:0] pred, input logic [1:0] fault);
    fb_if.fetch_valid_i       = 1'b1;
    fb_if.fetch_pc_i          = pc;
    fb_if.fetch_instr_i       = instr;
    fb_if.fetch_pred_branch_i = pred;
    fb_if.fetch_fault_i       = fault;
  endtask

  task automatic push(input logic [31:0] pc, input logic [63:0] instr,
                      input logic [1:0] pred, input logic [1:0] fault);
    set_pkt(pc, instr, pred, fault);
    step();
    idle();
  endtask

  task automatic accept(input logic a0, input logic a1);
    fb_if.issue0_accept_i = a0;
    fb_if.issue1_accept_i = a1;
    step();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_accept", 64'(fb_if.fetch_accept_o), 64'h1);
    chk("rst_v0", 64'(fb_if.issue0_valid_o), 64'h0);
    chk("rst_v1", 64'(fb_if.issue1_valid_o), 64'h0);

    // Accepts while empty must not underflow
    accept(1'b1, 1'b1);
    chk("empty_acc_v0", 64'(fb_if.issue0_valid_o), 64'h0);
    chk("empty_acc_accept", 64'(fb_if.fetch_accept_o), 64'h1);

    // Dual issue of a clean packet
    push(32'h1000, 64'h00200093_00100093, 2'b00, 2'b00);
    chk("dual_v0", 64'(fb_if.issue0_valid_o), 64'h1);
    chk("dual_pc0", 64'(fb_if.issue0_pc_o), 64'h1000);
    chk("dual_in0", 64'(fb_if.issue0_instr_o), 64'h00100093);
    chk("dual_v1", 64'(fb_if.issue1_valid_o), 64'h1);
    chk("dual_pc1", 64'(fb_if.issue1_pc_o), 64'h1004);
    chk("dual_in1", 64'(fb_if.issue1_instr_o), 64'h00200093);
    chk("dual_f1", 64'(fb_if.issue1_fault_o), 64'h0);
    accept(1'b1, 1'b1);
    chk("dual_empty_v0", 64'(fb_if.issue0_valid_o), 64'h0);
    chk("dual_empty_acc", 64'(fb_if.fetch_accept_o), 64'h1);

    // Single issue: low word then high word
    push(32'h1000, 64'h00200093_00100093, 2'b00, 2'b00);
    accept(1'b1, 1'b0);
    chk("half_v0", 64'(fb_if.issue0_valid_o), 64'h1);
    chk("half_pc0", 64'(fb_if.issue0_pc_o), 64'h1004);
    chk("half_in0", 64'(fb_if.issue0_instr_o), 64'h00200093);
    chk("half_v1", 64'(fb_if.issue1_valid_o), 64'h0);
    accept(1'b1, 1'b0);
    chk("half_pop_v0", 64'(fb_if.issue0_valid_o), 64'h0);

    // Predicted-taken slot0 drops slot1
    push(32'h2000, 64'hAAAA0002_BBBB0001, 2'b01, 2'b00);
    push(32'h3000, 64'h00300093_00400093, 2'b00, 2'b00);
    chk("pred_pc0", 64'(fb_if.issue0_pc_o), 64'h2000);
    chk("pred_p0", 64'(fb_if.issue0_pred_o), 64'h1);
    chk("pred_v1", 64'(fb_if.issue1_valid_o), 64'h0);
    accept(1'b1, 1'b1);
    chk("pred_next_pc0", 64'(fb_if.issue0_pc_o), 64'h3000);
    chk("pred_next_in0", 64'(fb_if.issue0_instr_o), 64'h00400093);
    chk("pred_next_v1", 64'(fb_if.issue1_valid_o), 64'h1);
    accept(1'b1, 1'b1);
    chk("pred_empty_v0", 64'(fb_if.issue0_valid_o), 64'h0);

    // Slot1 predicted-taken flag follows the word
    push(32'h6000, 64'hCCCC0002_DDDD0001, 2'b10, 2'b00);
    chk("p1_p0", 64'(fb_if.issue0_pred_o), 64'h0);
    chk("p1_p1", 64'(fb_if.issue1_pred_o), 64'h1);
    accept(1'b1, 1'b0);
    chk("p1_hi_pc", 64'(fb_if.issue0_pc_o), 64'h6004);
    chk("p1_hi_pred", 64'(fb_if.issue0_pred_o), 64'h1);
    accept(1'b1, 1'b0);
    chk("p1_empty_v0", 64'(fb_if.issue0_valid_o), 64'h0);

    // Fill, overflow attempt, push with dual pop at count 3
    push(32'h0100, 64'h1, 2'b00, 2'b00);
    push(32'h0108, 64'h2, 2'b00, 2'b00);
    push(32'h0110, 64'h3, 2'b00, 2'b00);
    chk("fill3_accept", 64'(fb_if.fetch_accept_o), 64'h1);
    push(32'h0118, 64'h4, 2'b00, 2'b00);
    chk("fill4_accept", 64'(fb_if.fetch_accept_o), 64'h0);
    push(32'h0500, 64'h5, 2'b00, 2'b00);
    chk("full_pc0", 64'(fb_if.issue0_pc_o), 64'h0100);
    accept(1'b1, 1'b1);
    chk("after_pop_pc0", 64'(fb_if.issue0_pc_o), 64'h0108);
    chk("after_pop_acc", 64'(fb_if.fetch_accept_o), 64'h1);
    set_pkt(32'h0600, 64'h6, 2'b00, 2'b00);
    accept(1'b1, 1'b1);
    chk("pp_accept", 64'(fb_if.fetch_accept_o), 64'h1);
    chk("pp_pc0", 64'(fb_if.issue0_pc_o), 64'h0110);
    push(32'h0610, 64'h7, 2'b00, 2'b00);
    chk("pp_refill_acc", 64'(fb_if.fetch_accept_o), 64'h0);
    accept(1'b1, 1'b1);
    chk("pp_pc0_b", 64'(fb_if.issue0_pc_o), 64'h0118);

    // Flush with 3 queued dominates a concurrent push
    set_pkt(32'h0700, 64'h8, 2'b00, 2'b00);
    fb_if.flush_i = 1'b1;
    step();
    idle();
    chk("flush_v0", 64'(fb_if.issue0_valid_o), 64'h0);
    chk("flush_acc", 64'(fb_if.fetch_accept_o), 64'h1);

    // Faulting packet issues only its low word
    push(32'h4000, 64'h11111111_22222222, 2'b00, 2'b01);
    chk("fault_f0", 64'(fb_if.issue0_fault_o), 64'h1);
    chk("fault_pc0", 64'(fb_if.issue0_pc_o), 64'h4000);
    chk("fault_v1", 64'(fb_if.issue1_valid_o), 64'h0);
    accept(1'b1, 1'b1);
    chk("fault_pop_v0", 64'(fb_if.issue0_valid_o), 64'h0);

    // Reset mid-operation with lo_done set
    push(32'h8000, 64'h9, 2'b00, 2'b00);
    push(32'h8008, 64'hA, 2'b00, 2'b00);
    accept(1'b1, 1'b0);
    chk("pre_rst_pc0", 64'(fb_if.issue0_pc_o), 64'h8004);
    set_pkt(32'h9000, 64'hB, 2'b00, 2'b00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("mid_rst_v0", 64'(fb_if.issue0_valid_o), 64'h0);
    chk("mid_rst_acc", 64'(fb_if.fetch_accept_o), 64'h1);
    push(32'h5000, 64'h55555555_66666666, 2'b00, 2'b00);
    chk("post_rst_pc0", 64'(fb_if.issue0_pc_o), 64'h5000);
    chk("post_rst_in0", 64'(fb_if.issue0_instr_o), 64'h66666666);
    chk("post_rst_v1", 64'(fb_if.issue1_valid_o), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
